// File: rtl/acc_cpu_pkg.sv
// Shared opcode and FSM state encodings for the accumulator CPU.
package acc_cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    ST_HALT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EX_LOAD  = 4'd3,
    ST_EX_STORE = 4'd4,
    ST_EX_ADD   = 4'd5,
    ST_EX_SUB   = 4'd6,
    ST_EX_IN    = 4'd7,
    ST_EX_JZ    = 4'd8,
    ST_EX_JPOS  = 4'd9,
    ST_EX_HALT  = 4'd10
  } state_t;

  function automatic state_t execState(input logic [2:0] op);
    state_t s;
    case (op)
      OP_LOAD:  s = ST_EX_LOAD;
      OP_STORE: s = ST_EX_STORE;
      OP_ADD:   s = ST_EX_ADD;
      OP_SUB:   s = ST_EX_SUB;
      OP_IN:    s = ST_EX_IN;
      OP_JZ:    s = ST_EX_JZ;
      OP_JPOS:  s = ST_EX_JPOS;
      default:  s = ST_EX_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/acc_cpu_mem.sv
// Unified program/data RAM: asynchronous read, single synchronous write port
// shared between the program-load path and STORE instructions.
module acc_cpu_mem
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              i_progWe,
  input  logic [ADDR_W-1:0] i_progAddr,
  input  logic [DATA_W-1:0] i_progData,
  input  logic              i_storeWe,
  input  logic [ADDR_W-1:0] i_storeAddr,
  input  logic [DATA_W-1:0] i_storeData,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // i_progWe is pre-qualified by the core, so it only wins while not executing
  always_comb begin
    w_we    = i_progWe | i_storeWe;
    w_waddr = i_progWe ? i_progAddr : i_storeAddr;
    w_wdata = i_progWe ? i_progData : i_storeData;
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FSM, PC/IR/A datapath, memory-mapped output
// at the top address, and a program-load port usable in reset or HALT.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] OUT_ADDR = {ADDR_W{1'b1}};

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir, r_acc, r_outData;
  logic              r_outValid;

  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr, w_memAddr;
  logic [DATA_W-1:0] w_memData;
  logic              w_aeq0, w_apos, w_progWe, w_storeWe;

  assign w_opcode  = r_ir[DATA_W-1 -: 3];
  assign w_addr    = r_ir[ADDR_W-1:0];
  assign w_aeq0    = (r_acc == '0);
  assign w_apos    = !r_acc[DATA_W-1] && !w_aeq0;
  assign w_memAddr = (r_state == ST_FETCH) ? r_pc : w_addr;

  // Loading is locked out while a program runs; a reset cycle suppresses STORE
  assign w_progWe  = prog_we && (!reset || r_state == ST_HALT);
  assign w_storeWe = reset && (r_state == ST_EX_STORE);

  acc_cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clock       (clock),
    .i_progWe    (w_progWe),
    .i_progAddr  (prog_addr),
    .i_progData  (prog_data),
    .i_storeWe   (w_storeWe),
    .i_storeAddr (w_addr),
    .i_storeData (r_acc),
    .i_raddr     (w_memAddr),
    .o_rdata     (w_memData)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_HALT;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_HALT:    if (start) w_nextState = ST_FETCH;
      ST_FETCH:   w_nextState = ST_DECODE;
      ST_DECODE:  w_nextState = execState(w_opcode);
      ST_EX_IN:   if (in_valid) w_nextState = ST_FETCH;
      ST_EX_HALT: w_nextState = ST_HALT;
      default:    w_nextState = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_acc      <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        ST_HALT:    if (start) r_pc <= '0;
        ST_FETCH: begin
          r_ir <= w_memData;
          r_pc <= r_pc + PC_ONE;
        end
        ST_EX_LOAD: r_acc <= w_memData;
        ST_EX_ADD:  r_acc <= r_acc + w_memData;
        ST_EX_SUB:  r_acc <= r_acc - w_memData;
        ST_EX_IN:   if (in_valid) r_acc <= in_data;
        ST_EX_JZ:   if (w_aeq0) r_pc <= w_addr;
        ST_EX_JPOS: if (w_apos) r_pc <= w_addr;
        ST_EX_STORE: begin
          if (w_addr == OUT_ADDR) begin
            r_outData  <= r_acc;
            r_outValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_EX_IN);
  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign halted    = (r_state == ST_HALT);
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign ir        = r_ir;
  assign dbg_state = r_state;

endmodule
